// File: rtl/humanlike_time_pkg.sv
// Shared time-word layout, field limits and presenter state type for the
// wall-clock timer and its alarm scheduler.
package humanlike_time_pkg;

    localparam int unsigned TIME_W = 27;

    localparam int unsigned MS_LSB = 0;
    localparam int unsigned MS_W   = 10;
    localparam int unsigned S_LSB  = 10;
    localparam int unsigned S_W    = 6;
    localparam int unsigned M_LSB  = 16;
    localparam int unsigned M_W    = 6;
    localparam int unsigned H_LSB  = 22;
    localparam int unsigned H_W    = 5;

    localparam logic [MS_W-1:0] MS_MAX = 10'd999;
    localparam logic [S_W-1:0]  S_MAX  = 6'd59;
    localparam logic [M_W-1:0]  M_MAX  = 6'd59;

    typedef enum logic [0:0] {
        IDLE,
        PRESENT
    } pres_state_e;

    // Hours are unrestricted; only sub-hour fields can hold impossible values.
    function automatic logic time_fields_ok(input logic [TIME_W-1:0] t);
        return (t[MS_LSB +: MS_W] <= MS_MAX) &&
               (t[S_LSB +: S_W] <= S_MAX) &&
               (t[M_LSB +: M_W] <= M_MAX);
    endfunction

endpackage

// File: rtl/alarm_scheduler_if.sv
// Programming, presentation handshake and status signals of the alarm scheduler.
interface alarm_scheduler_if
    import humanlike_time_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 4
);
    localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);

    logic [TIME_W-1:0]    time_in;
    logic                 wr_en;
    logic [SLOT_W-1:0]    wr_slot;
    logic [TIME_W-1:0]    wr_time;
    logic                 wr_arm;
    logic                 wr_repeat;
    logic                 alarm_valid;
    logic [SLOT_W-1:0]    alarm_slot;
    logic [TIME_W-1:0]    alarm_time;
    logic                 alarm_ack;
    logic [NUM_SLOTS-1:0] armed;
    logic [NUM_SLOTS-1:0] overrun;

    modport master (
        output time_in, wr_en, wr_slot, wr_time, wr_arm, wr_repeat, alarm_ack,
        input  alarm_valid, alarm_slot, alarm_time, armed, overrun
    );

    modport slave (
        input  time_in, wr_en, wr_slot, wr_time, wr_arm, wr_repeat, alarm_ack,
        output alarm_valid, alarm_slot, alarm_time, armed, overrun
    );

endinterface

// File: rtl/alarm_slot.sv
// One alarm slot: programmed time, arm/repeat flags, and the pending/overrun
// bookkeeping driven by tick matches, writes and presenter acks.
module alarm_slot
    import humanlike_time_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              tick_i,
    input  logic [TIME_W-1:0] time_in_i,
    input  logic              wr_en_i,
    input  logic [TIME_W-1:0] wr_time_i,
    input  logic              wr_arm_i,
    input  logic              wr_repeat_i,
    input  logic              ack_clr_i,
    output logic [TIME_W-1:0] slot_time_o,
    output logic              armed_o,
    output logic              pending_o,
    output logic              overrun_o
);

    logic [TIME_W-1:0] slot_time_q, slot_time_d;
    logic              armed_q, armed_d;
    logic              repeat_q, repeat_d;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic              match;

    assign match = tick_i && armed_q && (slot_time_q == time_in_i) &&
                   time_fields_ok(slot_time_q);

    always_comb begin
        slot_time_d = slot_time_q;
        armed_d     = armed_q;
        repeat_d    = repeat_q;
        pending_d   = pending_q;
        overrun_d   = overrun_q;
        if (wr_en_i) begin
            slot_time_d = wr_time_i;
            armed_d     = wr_arm_i;
            repeat_d    = wr_repeat_i;
            pending_d   = 1'b0;
            overrun_d   = 1'b0;
        end else if (match) begin
            // An ack landing with a fresh match leaves the slot pending, not overrun.
            if (pending_q && !ack_clr_i) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
            if (!repeat_q) begin
                armed_d = 1'b0;
            end
        end else if (ack_clr_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_time_q <= '0;
            armed_q     <= 1'b0;
            repeat_q    <= 1'b0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            slot_time_q <= slot_time_d;
            armed_q     <= armed_d;
            repeat_q    <= repeat_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
        end
    end

    assign slot_time_o = slot_time_q;
    assign armed_o     = armed_q;
    assign pending_o   = pending_q;
    assign overrun_o   = overrun_q;

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm controller: detects timer ticks, matches them against the
// slots and presents pending alarms one at a time, lowest index first.
module alarm_scheduler
    import humanlike_time_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 4
) (
    input logic               clock,
    input logic               reset,
    alarm_scheduler_if.slave  bus
);

    localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);

    logic [TIME_W-1:0]    time_q, time_d;
    logic                 first_q, first_d;
    logic                 tick;
    pres_state_e          state_q, state_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [TIME_W-1:0]    atime_q, atime_d;
    logic [NUM_SLOTS-1:0] wr_sel;
    logic [NUM_SLOTS-1:0] ack_sel;
    logic [NUM_SLOTS-1:0] pending;
    logic [NUM_SLOTS-1:0] avail;
    logic [SLOT_W-1:0]    pick;
    logic [TIME_W-1:0]    slot_time [NUM_SLOTS];

    // first_q forces one tick after reset so a time-zero alarm can fire.
    assign tick = first_q || (bus.time_in != time_q);

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        assign wr_sel[i] = bus.wr_en && (bus.wr_slot == SLOT_W'(i));

        alarm_slot u_slot (
            .clock       (clock),
            .reset       (reset),
            .tick_i      (tick),
            .time_in_i   (bus.time_in),
            .wr_en_i     (wr_sel[i]),
            .wr_time_i   (bus.wr_time),
            .wr_arm_i    (bus.wr_arm),
            .wr_repeat_i (bus.wr_repeat),
            .ack_clr_i   (ack_sel[i]),
            .slot_time_o (slot_time[i]),
            .armed_o     (bus.armed[i]),
            .pending_o   (pending[i]),
            .overrun_o   (bus.overrun[i])
        );
    end

    // A slot being rewritten this cycle loses its pending flag, so skip it.
    assign avail = pending & ~wr_sel;

    always_comb begin
        pick = '0;
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            if (avail[i]) begin
                pick = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        time_d  = bus.time_in;
        first_d = 1'b0;
        state_d = state_q;
        slot_d  = slot_q;
        atime_d = atime_q;
        ack_sel = '0;
        unique case (state_q)
            IDLE: begin
                if (|avail) begin
                    state_d = PRESENT;
                    slot_d  = pick;
                    atime_d = slot_time[pick];
                end
            end
            PRESENT: begin
                if (wr_sel[slot_q]) begin
                    state_d = IDLE;
                end else if (bus.alarm_ack) begin
                    ack_sel[slot_q] = 1'b1;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            time_q  <= '0;
            first_q <= 1'b1;
            state_q <= IDLE;
            slot_q  <= '0;
            atime_q <= '0;
        end else begin
            time_q  <= time_d;
            first_q <= first_d;
            state_q <= state_d;
            slot_q  <= slot_d;
            atime_q <= atime_d;
        end
    end

    assign bus.alarm_valid = (state_q == PRESENT);
    assign bus.alarm_slot  = slot_q;
    assign bus.alarm_time  = atime_q;

endmodule
